spi_buffer_sched: RTL

//   Double-buffer scheduler for the SPI slave PU. Owns two spi_buffer banks (A/B) and drives their wr/oe strobes.
//   The processor side fills one bank while the SPI transfer side drains the other.

---
 rtl/spi_buffer_sched.sv | 84 ++++++++
 1 files changed

// File: rtl/spi_buffer_sched.sv
// Double-buffer scheduler for the SPI slave: the processor fills one bank while SPI drains the other.
// Strobes are combinational; counters and bank swap update on posedge clk, swap deferred while SPI is busy.
module spi_buffer_sched #(
  parameter int BUF_SIZE   = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  cycle_end,
  input  logic                  spi_busy,
  input  logic                  spi_ready,
  output logic                  bank_sel,
  output logic                  buf_wr_a,
  output logic                  buf_wr_b,
  output logic                  buf_oe_a,
  output logic                  buf_oe_b,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [ADDR_WIDTH-1:0] send_addr,
  output logic [ADDR_WIDTH-1:0] send_len,
  output logic                  swap_done,
  output logic                  waiting,
  output logic                  overflow,
  output logic                  underrun
);

  localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(BUF_SIZE);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_SWAP} state_t;

  state_t state, state_nxt;
  logic   wr_ok, rd_ok;

  // Strobes are forced low during reset so every output reads 0.
  assign wr_ok = !rst && wr && (fill_addr < FULL);
  assign rd_ok = !rst && spi_ready && (state != S_SWAP) && (send_addr < send_len);

  assign buf_wr_a  = wr_ok && !bank_sel;
  assign buf_wr_b  = wr_ok &&  bank_sel;
  assign buf_oe_a  = rd_ok &&  bank_sel;
  assign buf_oe_b  = rd_ok && !bank_sel;
  assign waiting   = (state == S_WAIT);
  assign swap_done = (state == S_SWAP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: if (cycle_end) state_nxt = spi_busy ? S_WAIT : S_SWAP;
      S_WAIT: if (!spi_busy) state_nxt = S_SWAP;
      S_SWAP: state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel  <= 1'b0;
      fill_addr <= '0;
      send_addr <= '0;
      send_len  <= '0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= spi_ready && !rd_ok;
      if (wr && (fill_addr == FULL)) overflow <= 1'b1;
      if (state == S_SWAP) begin
        // A word written during the swap cycle still belongs to the closing frame.
        bank_sel  <= !bank_sel;
        send_len  <= fill_addr + ADDR_WIDTH'(wr_ok);
        fill_addr <= '0;
        send_addr <= '0;
      end else begin
        if (wr_ok) fill_addr <= fill_addr + 1'b1;
        if (rd_ok) send_addr <= send_addr + 1'b1;
      end
    end
  end

endmodule
